// File: rtl/pll_scan_loader_pkg.sv
// Shared constants and types for the PLL scan-chain loader: default chain
// geometry, counter widths and the controller state encoding.
package pll_scan_loader_pkg;

  localparam int DEF_SCAN_LEN = 144;
  localparam int DEF_ROM_LAT  = 2;
  localparam int DEF_TIMEOUT  = 4096;

  // ROM index width; the chain length must not exceed 2**ADDR_W bits.
  localparam int ADDR_W  = 8;
  // Per-state cycle counter; wide enough to reach the default timeout.
  localparam int TIMER_W = 13;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    WAIT_RECONF,
    UPDATE,
    WAIT_DONE,
    WAIT_LOCK
  } state_t;

  // States in which the controller is waiting on the ROM or PLL and can time out.
  function automatic logic is_wait_state(input state_t s);
    return (s == WAIT_RECONF) || (s == WAIT_DONE) || (s == WAIT_LOCK);
  endfunction

endpackage

// File: rtl/pll_scan_loader_if.sv
// Bundle of the ROM read port and the PLL reconfiguration port driven by the
// loader. The loader is the master; the ROM/PLL side is the slave.
interface pll_scan_loader_if;
  import pll_scan_loader_pkg::*;

  logic [ADDR_W-1:0] rom_address;
  logic              rom_read_ena;
  logic              rom_q;
  logic              rom_reconfig;
  logic              pll_scanclkena;
  logic              pll_scandata;
  logic              pll_configupdate;
  logic              pll_scandone;
  logic              pll_locked;

  modport master (
    output rom_address, rom_read_ena,
    output pll_scanclkena, pll_scandata, pll_configupdate,
    input  rom_q, rom_reconfig,
    input  pll_scandone, pll_locked
  );

  modport slave (
    input  rom_address, rom_read_ena,
    input  pll_scanclkena, pll_scandata, pll_configupdate,
    output rom_q, rom_reconfig,
    output pll_scandone, pll_locked
  );

endinterface

// File: rtl/pll_scan_delay.sv
// Fixed-depth shift register that delays the ROM read enable by the ROM read
// latency so it lines up with the data bit returned for the same address.
module pll_scan_delay
  import pll_scan_loader_pkg::*;
#(
  parameter int LAT = DEF_ROM_LAT
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [LAT-1:0] taps;

  // Shift the enable one tap per cycle; reset empties the line so a load cut
  // short by reset stops shifting immediately.
  always_ff @(posedge clock) begin
    if (reset) begin
      taps <= '0;
    end else begin
      taps[0] <= din;
      for (int i = 1; i < LAT; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

  assign dout = taps[LAT-1];

endmodule

// File: rtl/pll_scan_loader.sv
// Streams a PLL scan chain out of a ROM and sequences the PLL update:
// read SCAN_LEN bits, wait for the ROM's reconfig authorisation, strobe
// configupdate, then wait for scandone and lock. Wait states time out.
module pll_scan_loader
  import pll_scan_loader_pkg::*;
#(
  parameter int SCAN_LEN = DEF_SCAN_LEN,
  parameter int ROM_LAT  = DEF_ROM_LAT,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              trigger,
  output logic              busy,
  output logic              error,
  pll_scan_loader_if.master bus
);

  localparam logic [ADDR_W-1:0]  LAST_ADDR    = ADDR_W'(SCAN_LEN - 1);
  localparam logic [TIMER_W-1:0] DRAIN_LAST   = TIMER_W'(ROM_LAT - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT - 1);

  state_t              state;
  logic [ADDR_W-1:0]   rom_addr;
  logic                read_ena;
  logic                config_update;
  logic                pending;
  logic                reconfig_seen;
  logic                scandone_q;
  logic [TIMER_W-1:0]  timer;
  logic                scan_ena;
  logic                timed_out;

  assign timed_out = is_wait_state(state) && (timer == TIMEOUT_LAST);

  // Controller: one register set for state, ROM address, strobes and flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      rom_addr      <= '0;
      read_ena      <= 1'b0;
      config_update <= 1'b0;
      busy          <= 1'b0;
      error         <= 1'b0;
      pending       <= 1'b0;
      reconfig_seen <= 1'b0;
      scandone_q    <= 1'b0;
      timer         <= '0;
    end else begin
      scandone_q    <= bus.pll_scandone;
      config_update <= 1'b0;
      timer         <= timer + TIMER_W'(1);
      if (trigger && (state != IDLE)) begin
        pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          timer <= '0;
          if (trigger || pending) begin
            state         <= READ;
            busy          <= 1'b1;
            error         <= 1'b0;
            rom_addr      <= '0;
            read_ena      <= 1'b1;
            pending       <= 1'b0;
            reconfig_seen <= 1'b0;
          end
        end
        READ: begin
          if (rom_addr == LAST_ADDR) begin
            state    <= DRAIN;
            read_ena <= 1'b0;
            timer    <= '0;
          end else begin
            rom_addr <= rom_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (bus.rom_reconfig) begin
            reconfig_seen <= 1'b1;
          end
          if (timer == DRAIN_LAST) begin
            state <= WAIT_RECONF;
            timer <= '0;
          end
        end
        WAIT_RECONF: begin
          if (bus.rom_reconfig || reconfig_seen) begin
            state         <= UPDATE;
            config_update <= 1'b1;
            reconfig_seen <= 1'b0;
            timer         <= '0;
          end else if (timed_out) begin
            state <= IDLE;
            busy  <= 1'b0;
            error <= 1'b1;
            timer <= '0;
          end
        end
        UPDATE: begin
          state <= WAIT_DONE;
          timer <= '0;
        end
        WAIT_DONE: begin
          if (bus.pll_scandone && !scandone_q) begin
            state <= WAIT_LOCK;
            timer <= '0;
          end else if (timed_out) begin
            state <= IDLE;
            busy  <= 1'b0;
            error <= 1'b1;
            timer <= '0;
          end
        end
        WAIT_LOCK: begin
          if (bus.pll_locked) begin
            state <= IDLE;
            busy  <= 1'b0;
            timer <= '0;
          end else if (timed_out) begin
            state <= IDLE;
            busy  <= 1'b0;
            error <= 1'b1;
            timer <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          timer <= '0;
        end
      endcase
    end
  end

  pll_scan_delay #(
    .LAT (ROM_LAT)
  ) u_delay (
    .clock (clock),
    .reset (reset),
    .din   (read_ena),
    .dout  (scan_ena)
  );

  assign bus.rom_address      = rom_addr;
  assign bus.rom_read_ena     = read_ena;
  assign bus.pll_scanclkena   = scan_ena;
  assign bus.pll_scandata     = scan_ena & bus.rom_q;
  assign bus.pll_configupdate = config_update;

endmodule

// File: tb/tb_pll_scan_loader.sv
// Directed bench for pll_scan_loader with a ROM model (bit = addr[0]),
// a reconfig pulse generator and a simple PLL model.
module tb_pll_scan_loader;

  logic clock = 1'b0;
  logic reset;
  logic trigger;
  logic busy;
  logic error;

  int checks = 0;
  int errors = 0;

  pll_scan_loader_if bus();

  pll_scan_loader dut (
    .clock   (clock),
    .reset   (reset),
    .trigger (trigger),
    .busy    (busy),
    .error   (error),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // ROM model: two-cycle read latency, data bit equals address bit 0.
  logic rom_q1 = 1'b0;
  logic rom_q2 = 1'b0;
  always @(posedge clock) begin
    rom_q1 <= bus.rom_address[0];
    rom_q2 <= rom_q1;
  end
  assign bus.rom_q = rom_q2;

  // ROM reconfig pulse three cycles after read enable falls (or one cycle
  // after, landing in DRAIN, when reconfig_early is set).
  logic       ena_d = 1'b0;
  logic [2:0] rc_sr = 3'b000;
  logic       reconfig_early = 1'b0;
  always @(posedge clock) begin
    ena_d <= bus.rom_read_ena;
    rc_sr <= {rc_sr[1:0], ena_d & ~bus.rom_read_ena};
  end
  assign bus.rom_reconfig = reconfig_early ? rc_sr[0] : rc_sr[2];

  // PLL model: update drops scandone/locked; scandone returns 9 cycles
  // later and lock 4 cycles after that, unless pll_hang is set.
  logic scandone   = 1'b0;
  logic locked     = 1'b1;
  logic pll_active = 1'b0;
  logic pll_hang   = 1'b0;
  int   pll_cnt    = 0;
  always @(posedge clock) begin
    if (bus.pll_configupdate) begin
      scandone   <= 1'b0;
      locked     <= 1'b0;
      pll_cnt    <= 0;
      pll_active <= 1'b1;
    end else if (pll_active && !pll_hang) begin
      pll_cnt <= pll_cnt + 1;
      if (pll_cnt == 8) scandone <= 1'b1;
      if (pll_cnt == 12) begin
        locked     <= 1'b1;
        pll_active <= 1'b0;
      end
    end
  end
  assign bus.pll_scandone = scandone;
  assign bus.pll_locked   = locked;

  // Shift/update monitor: counts shifted bits, checks the bit pattern and
  // configupdate rules, accumulating violation counts for later checks.
  int   total_bits   = 0;
  int   load_bit     = 0;
  int   update_count = 0;
  int   data_errs    = 0;
  int   overlap_errs = 0;
  int   width_errs   = 0;
  int   early_errs   = 0;
  logic prev_update  = 1'b0;
  always @(negedge clock) begin
    if (reset) begin
      load_bit    = 0;
      prev_update = 1'b0;
    end else begin
      if (bus.pll_scanclkena) begin
        if (bus.pll_scandata !== load_bit[0]) data_errs++;
        load_bit++;
        total_bits++;
      end
      if (bus.pll_configupdate) begin
        update_count++;
        if (bus.pll_scanclkena) overlap_errs++;
        if (prev_update) width_errs++;
        if (load_bit != 144) early_errs++;
        load_bit = 0;
      end
      prev_update = bus.pll_configupdate;
    end
  end

  // Compare one observed value against its expected value.
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Hold trigger high across 'hold' rising edges.
  task automatic apply_stimulus(input int hold);
    @(posedge clock); #1;
    trigger = 1'b1;
    repeat (hold) begin
      @(posedge clock); #1;
    end
    trigger = 1'b0;
  endtask

  // From a negedge, count negedges with busy high until it drops.
  task automatic wait_idle(input string tag, input int limit, output int cycles);
    cycles = 0;
    while (busy && cycles < limit) begin
      cycles++;
      @(negedge clock);
    end
    check_output({tag, "_idle_reached"}, 32'(busy), 32'd0);
  endtask

  int cyc;
  int bits0;
  int upd0;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset   = 1'b1;
    trigger = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_output("rst_addr",   32'(bus.rom_address),      32'd0);
    check_output("rst_rdena",  32'(bus.rom_read_ena),     32'd0);
    check_output("rst_scnena", 32'(bus.pll_scanclkena),   32'd0);
    check_output("rst_scndat", 32'(bus.pll_scandata),     32'd0);
    check_output("rst_cfgupd", 32'(bus.pll_configupdate), 32'd0);
    check_output("rst_busy",   32'(busy),                 32'd0);
    check_output("rst_error",  32'(error),                32'd0);

    $display("[TB] single load");
    bits0 = total_bits; upd0 = update_count;
    apply_stimulus(1);
    @(negedge clock);
    check_output("t1_busy",  32'(busy),             32'd1);
    check_output("t1_addr0", 32'(bus.rom_address),  32'd0);
    check_output("t1_rdena", 32'(bus.rom_read_ena), 32'd1);
    wait_idle("t1", 1000, cyc);
    check_output("t1_busy_cycles", 32'(cyc), 32'd163);
    @(posedge clock); #1;
    check_output("t1_bits",    32'(total_bits - bits0),   32'd144);
    check_output("t1_updates", 32'(update_count - upd0),  32'd1);
    check_output("t1_data",    32'(data_errs),            32'd0);
    check_output("t1_error",   32'(error),                32'd0);

    $display("[TB] reconfig during drain");
    reconfig_early = 1'b1;
    bits0 = total_bits;
    apply_stimulus(1);
    @(negedge clock);
    wait_idle("t2", 6000, cyc);
    check_output("t2_busy_cycles", 32'(cyc), 32'd162);
    @(posedge clock); #1;
    check_output("t2_bits",  32'(total_bits - bits0), 32'd144);
    check_output("t2_error", 32'(error),              32'd0);
    reconfig_early = 1'b0;

    $display("[TB] trigger during load");
    bits0 = total_bits; upd0 = update_count;
    apply_stimulus(1);
    repeat (48) begin
      @(posedge clock); #1;
    end
    apply_stimulus(1);
    @(negedge clock);
    wait_idle("t3a", 1000, cyc);
    check_output("t3_first_cycles", 32'(cyc), 32'd113);
    @(negedge clock);
    check_output("t3_restart_busy", 32'(busy),             32'd1);
    check_output("t3_restart_addr", 32'(bus.rom_address),  32'd0);
    check_output("t3_restart_rden", 32'(bus.rom_read_ena), 32'd1);
    wait_idle("t3b", 1000, cyc);
    check_output("t3_second_cycles", 32'(cyc), 32'd163);
    @(posedge clock); #1;
    check_output("t3_bits",    32'(total_bits - bits0),  32'd288);
    check_output("t3_updates", 32'(update_count - upd0), 32'd2);

    $display("[TB] trigger held three cycles");
    bits0 = total_bits; upd0 = update_count;
    apply_stimulus(3);
    @(negedge clock);
    wait_idle("t4a", 1000, cyc);
    check_output("t4_first_cycles", 32'(cyc), 32'd161);
    @(negedge clock);
    wait_idle("t4b", 1000, cyc);
    check_output("t4_second_cycles", 32'(cyc), 32'd163);
    repeat (5) @(negedge clock);
    check_output("t4_no_third", 32'(busy), 32'd0);
    @(posedge clock); #1;
    check_output("t4_bits",    32'(total_bits - bits0),  32'd288);
    check_output("t4_updates", 32'(update_count - upd0), 32'd2);

    $display("[TB] scandone timeout");
    pll_hang = 1'b1;
    bits0 = total_bits;
    apply_stimulus(1);
    @(negedge clock);
    wait_idle("t5", 6000, cyc);
    check_output("t5_abort_cycles", 32'(cyc),   32'd4245);
    check_output("t5_error_set",    32'(error), 32'd1);
    @(posedge clock); #1;
    check_output("t5_bits", 32'(total_bits - bits0), 32'd144);
    pll_hang = 1'b0;
    apply_stimulus(1);
    @(negedge clock);
    check_output("t5_error_cleared", 32'(error), 32'd0);
    wait_idle("t5b", 1000, cyc);
    check_output("t5_reload_cycles", 32'(cyc),   32'd163);
    check_output("t5_reload_error",  32'(error), 32'd0);

    $display("[TB] reset mid-shift");
    apply_stimulus(1);
    repeat (70) begin
      @(posedge clock); #1;
    end
    reset   = 1'b1;
    trigger = 1'b1;
    @(negedge clock);
    check_output("t6_addr70", 32'(bus.rom_address), 32'd70);
    @(posedge clock); #1;
    reset   = 1'b0;
    trigger = 1'b0;
    @(negedge clock);
    check_output("t6_addr",   32'(bus.rom_address),      32'd0);
    check_output("t6_rdena",  32'(bus.rom_read_ena),     32'd0);
    check_output("t6_scnena", 32'(bus.pll_scanclkena),   32'd0);
    check_output("t6_scndat", 32'(bus.pll_scandata),     32'd0);
    check_output("t6_cfgupd", 32'(bus.pll_configupdate), 32'd0);
    check_output("t6_busy",   32'(busy),                 32'd0);
    check_output("t6_error",  32'(error),                32'd0);
    repeat (3) @(negedge clock);
    check_output("t6_trig_discarded", 32'(busy), 32'd0);
    @(posedge clock); #1;
    bits0 = total_bits; upd0 = update_count;
    apply_stimulus(1);
    @(negedge clock);
    check_output("t6_reload_addr", 32'(bus.rom_address), 32'd0);
    wait_idle("t6", 1000, cyc);
    check_output("t6_reload_cycles", 32'(cyc), 32'd163);
    @(posedge clock); #1;
    check_output("t6_bits",    32'(total_bits - bits0),  32'd144);
    check_output("t6_updates", 32'(update_count - upd0), 32'd1);

    check_output("data_pattern",   32'(data_errs),    32'd0);
    check_output("upd_overlap",    32'(overlap_errs), 32'd0);
    check_output("upd_width",      32'(width_errs),   32'd0);
    check_output("upd_after_144",  32'(early_errs),   32'd0);
    check_output("upd_total",      32'(update_count), 32'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
